csr_trap_ctrl: RTL and testbench
================================

# csr_trap_ctrl

Trap and return sequencer that drives the single-port machine-mode CSR file: on an exception, interrupt or `mret` it issues the required sequence of CSR reads and writes (mepc, mcause, mtval, mstatus, mtvec) and then issues a one-cycle PC redirect to the fetch stage. It sits between the execute/commit stage and the CSR file. It holds `busy` to stall the pipeline while the sequence runs.

## Interface
- `VECTORED_EN`, default 1: when 1, mtvec mode 1 (vectored) is honoured for interrupts; when 0, mtvec[1:0] is ignored and every trap uses direct mode.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `trap_req`  in  1  synchronous exception request from commit; sampled only in IDLE.
- `trap_cause`  in  32  mcause value for the exception; bit 31 must be 0.
- `trap_val`  in  32  mtval value for the exception.
- `mret_req`  in  1  `mret` request; sampled only in IDLE.
- `irq_req`  in  1  external/timer interrupt pending (level).
- `irq_code`  in  5  interrupt cause code.
- `cur_pc`  in  32  PC of the faulting or interrupted instruction.
- `csr_we`  out  1  CSR write enable.
- `csr_addr`  out  12  CSR address.
- `csr_wdata`  out  32  CSR write data.
- `csr_rdata`  in  32  combinational read data of the CSR at `csr_addr`.
- `busy`  out  1  sequence in progress; the pipeline holds while this is 1.
- `redirect_valid`  out  1  one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc`  out  32  new PC; word aligned.

## Operation
- CSR addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
- All outputs are combinational from the state and captured registers.
- **IDLE**
  - `csr_addr`=0x300, `csr_we`=0, `busy`=0, `redirect_valid`=0, `redirect_pc`=0.
  - Acceptance priority:
    1. `trap_req` captures epc=`cur_pc` & ~3, cause=`trap_cause`, tval=`trap_val`, then goes to T_EPC.
    2. else `mret_req` goes to M_STATUS.
    3. else `irq_req` is accepted only if `csr_rdata[3]` (mstatus.MIE) is 1. It captures epc=`cur_pc` & ~3, cause={1'b1, 26'b0, `irq_code`}, tval=0, then goes to T_EPC.
- **T_EPC**: write 0x341 ← epc.
- **T_CAUSE**: write 0x342 ← cause.
- **T_TVAL**: write 0x343 ← tval.
- **T_STATUS**: write 0x300 ← `csr_rdata` with bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits[12:11] (MPP)=2'b11. Other bits are unchanged.
- **T_REDIR**
  - `csr_addr`=0x305, `redirect_valid`=1, then return to IDLE.
  - base = {`csr_rdata`[31:2], 2'b00}.
  - If `VECTORED_EN` and `csr_rdata`[1:0]==1 and cause[31]==1: `redirect_pc` = base + (cause[4:0] << 2).
  - Otherwise `redirect_pc` = base.
  - The addition wraps modulo 2^32.
- **M_STATUS**: write 0x300 ← `csr_rdata` with bit3=old bit7, bit7=1, bits[12:11]=2'b11.
- **M_REDIR**: `csr_addr`=0x341, `redirect_valid`=1, `redirect_pc`=`csr_rdata` & ~3, then return to IDLE.
- In every state except IDLE: `busy`=1. `csr_we`=1 only in T_EPC, T_CAUSE, T_TVAL, T_STATUS and M_STATUS.
- Requests arriving while busy are ignored; the requester must hold or re-raise them.

## Timing
- Reset (asynchronous): state=IDLE, captured registers=0, all outputs at their IDLE values.
- Reset mid-sequence returns to IDLE immediately. No further CSR writes are issued, and writes already made are not undone.
- Trap/interrupt accepted at edge N:
  - writes occur in cycles N+1..N+4, and the CSR file commits each write before edge N+2..N+5;
  - redirect pulse in cycle N+5;
  - `busy` high for exactly 5 cycles;
  - IDLE again after edge N+5, so a new request can be accepted at edge N+6.
- `mret` accepted at edge N: mstatus write in cycle N+1, redirect in cycle N+2, `busy` high for 2 cycles.
- T_STATUS and M_STATUS perform read-modify-write in a single cycle: `csr_rdata` is read combinationally and written back the same cycle.
- Simultaneous requests: `trap_req` wins over `mret_req`, which wins over `irq_req`. The losing requests are dropped.

## Test plan
- Exception: mtvec=0x0000_0101, `trap_req` with cause=2, pc=0x0000_0104, val=0xDEAD_BEEF.
  - Expect mepc=0x104, mcause=2, mtval=0xDEADBEEF.
  - Expect mstatus MIE 1→0 with MPIE=1 and MPP=3.
  - Expect `redirect_pc`=0x100 in the 5th cycle after acceptance.
- Vectored interrupt: mtvec=0x0000_0201, MIE=1, `irq_code`=7, pc=0x200.
  - Expect mcause=0x8000_0007, mtval=0, `redirect_pc`=0x21C.
- Masked interrupt: mstatus=0 with `irq_req` held for 10 cycles → `busy` stays 0 and there are no CSR writes.
- mret: mepc=0x0000_0106, mstatus=0x0000_0080.
  - Expect mstatus=0x0000_1888 after the write.
  - Expect `redirect_pc`=0x104 one cycle later, and `busy` high for 2 cycles.
- Priority/busy: `trap_req`, `mret_req` and `irq_req` all asserted at the same edge.
  - Expect the trap sequence only.
  - An `mret_req` pulse during busy produces no effect.
- Reset during T_CAUSE: assert `rst` → `busy`=0 and `csr_we`=0 immediately; mepc is retained and mcause is unchanged.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: sequences the machine-mode CSR accesses for trap entry
// (exception or interrupt) and mret, then pulses a PC redirect to fetch.
// The CSR file is single-ported with combinational read data, so every
// state drives exactly one CSR address; status updates are read-modify-write
// within one cycle.
module csr_trap_ctrl #(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret_req,
  input  logic        irq_req,
  input  logic [4:0]  irq_code,
  input  logic [31:0] cur_pc,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_T_EPC    = 3'd1;
  localparam logic [2:0] S_T_CAUSE  = 3'd2;
  localparam logic [2:0] S_T_TVAL   = 3'd3;
  localparam logic [2:0] S_T_STATUS = 3'd4;
  localparam logic [2:0] S_T_REDIR  = 3'd5;
  localparam logic [2:0] S_M_STATUS = 3'd6;
  localparam logic [2:0] S_M_REDIR  = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] tval_q, tval_d;

  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;
  logic [31:0] tvec_base;
  logic [31:0] tvec_target;

  // State and captured trap context; reset abandons any sequence in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
      tval_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  // Request acceptance in IDLE (trap > mret > enabled irq), then a fixed walk.
  // In IDLE csr_addr points at mstatus, so csr_rdata[3] is the live MIE bit.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    case (state_q)
      S_IDLE: begin
        if (trap_req) begin
          epc_d   = {cur_pc[31:2], 2'b00};
          cause_d = trap_cause;
          tval_d  = trap_val;
          state_d = S_T_EPC;
        end else if (mret_req) begin
          state_d = S_M_STATUS;
        end else if (irq_req && csr_rdata[3]) begin
          epc_d   = {cur_pc[31:2], 2'b00};
          cause_d = {1'b1, 26'b0, irq_code};
          tval_d  = 32'h0;
          state_d = S_T_EPC;
        end
      end
      S_T_EPC:    state_d = S_T_CAUSE;
      S_T_CAUSE:  state_d = S_T_TVAL;
      S_T_TVAL:   state_d = S_T_STATUS;
      S_T_STATUS: state_d = S_T_REDIR;
      S_T_REDIR:  state_d = S_IDLE;
      S_M_STATUS: state_d = S_M_REDIR;
      S_M_REDIR:  state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Status rewrites and trap target derived from whatever the CSR file returns now.
  always_comb begin
    mstatus_trap        = csr_rdata;
    mstatus_trap[7]     = csr_rdata[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;

    mstatus_mret        = csr_rdata;
    mstatus_mret[3]     = csr_rdata[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;

    tvec_base = {csr_rdata[31:2], 2'b00};
    if (VECTORED_EN && (csr_rdata[1:0] == 2'b01) && cause_q[31])
      tvec_target = tvec_base + {25'b0, cause_q[4:0], 2'b00};
    else
      tvec_target = tvec_base;
  end

  // Output decode: one CSR address per state, writes only in the write states.
  always_comb begin
    csr_we         = 1'b0;
    csr_addr       = ADDR_MSTATUS;
    csr_wdata      = 32'h0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_T_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MEPC;
        csr_wdata = epc_q;
      end
      S_T_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MCAUSE;
        csr_wdata = cause_q;
      end
      S_T_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MTVAL;
        csr_wdata = tval_q;
      end
      S_T_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        csr_wdata = mstatus_trap;
      end
      S_T_REDIR: begin
        csr_addr       = ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = tvec_target;
      end
      S_M_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        csr_wdata = mstatus_mret;
      end
      S_M_REDIR: begin
        csr_addr       = ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_rdata[31:2], 2'b00};
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: drives csr_trap_ctrl against a behavioural CSR file and a
// transaction-level reference that expands each accepted request into the
// expected per-cycle bus activity.
module tb_csr_trap_ctrl;

  localparam bit VEC = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_req, mret_req, irq_req;
  logic [31:0] trap_cause, trap_val, cur_pc;
  logic [4:0]  irq_code;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.VECTORED_EN(VEC)) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_val(trap_val),
    .mret_req(mret_req), .irq_req(irq_req), .irq_code(irq_code),
    .cur_pc(cur_pc),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Behavioural CSR file (combinational read)
  logic [31:0] csr_mem [0:4095];
  bit          mem_init = 1'b0;
  assign csr_rdata = csr_mem[csr_addr];

  // Bench-side CSR preset port, only used while the DUT is idle with no requests
  logic        bw_en = 1'b0;
  logic [11:0] bw_addr = 12'h0;
  logic [31:0] bw_data = 32'h0;

  typedef struct packed {
    logic        busy;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];

  function automatic exp_t mk(logic b, logic w, logic [11:0] a, logic [31:0] d,
                              logic v, logic [31:0] p);
    exp_t e;
    e.busy = b; e.we = w; e.addr = a; e.wdata = d; e.rv = v; e.rpc = p;
    return e;
  endfunction

  // Expand a trap entry into its five expected cycles
  function automatic void push_trap(logic [31:0] epc, logic [31:0] cause, logic [31:0] tval);
    logic [31:0] ms, tv, ns, base, tgt;
    ms   = csr_mem[12'h300];
    tv   = csr_mem[12'h305];
    ns   = (ms & ~32'h0000_1888) | (ms[3] ? 32'h80 : 32'h0) | 32'h0000_1800;
    base = tv & ~32'h3;
    if (VEC && tv[1:0] == 2'd1 && cause[31]) tgt = base + 32'(cause[4:0]) * 4;
    else tgt = base;
    exp_q.push_back(mk(1'b1, 1'b1, 12'h341, epc,   1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h342, cause, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h343, tval,  1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ns,    1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b0, 12'h305, 32'h0, 1'b1, tgt));
  endfunction

  function automatic void push_mret();
    logic [31:0] ms, ns;
    ms = csr_mem[12'h300];
    ns = (ms & ~32'h0000_1888) | (ms[7] ? 32'h8 : 32'h0) | 32'h0000_1880;
    exp_q.push_back(mk(1'b1, 1'b1, 12'h300, ns, 1'b0, 32'h0));
    exp_q.push_back(mk(1'b1, 1'b0, 12'h341, 32'h0, 1'b1, csr_mem[12'h341] & ~32'h3));
  endfunction

  // Reference model step plus CSR file commit, in one process so the model
  // always sees the pre-edge CSR contents
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      if (!mem_init) begin
        csr_mem[12'h300] = 32'h0;
        csr_mem[12'h305] = 32'h0;
        csr_mem[12'h341] = 32'h0;
        csr_mem[12'h342] = 32'h0;
        csr_mem[12'h343] = 32'h0;
        mem_init = 1'b1;
      end
    end else begin
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end else if (trap_req) begin
        push_trap(cur_pc & ~32'h3, trap_cause, trap_val);
      end else if (mret_req) begin
        push_mret();
      end else if (irq_req && csr_mem[12'h300][3]) begin
        push_trap(cur_pc & ~32'h3, {1'b1, 26'b0, irq_code}, 32'h0);
      end
      if (bw_en) csr_mem[bw_addr] = bw_data;
      if (csr_we) csr_mem[csr_addr] = csr_wdata;
    end
  end

  // Per-cycle compare against the model
  exp_t e_cmp, a_cmp;
  always @(negedge clk) begin
    if (mem_init) begin
      e_cmp = (exp_q.size() > 0) ? exp_q[0] : mk(1'b0, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0);
      a_cmp = mk(busy, csr_we, csr_addr, csr_we ? csr_wdata : 32'h0, redirect_valid, redirect_pc);
      n_cmp++;
      if (a_cmp !== e_cmp) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got busy=%b we=%b addr=%h wdata=%h rv=%b rpc=%h, expected busy=%b we=%b addr=%h wdata=%h rv=%b rpc=%h",
                 $time, a_cmp.busy, a_cmp.we, a_cmp.addr, a_cmp.wdata, a_cmp.rv, a_cmp.rpc,
                 e_cmp.busy, e_cmp.we, e_cmp.addr, e_cmp.wdata, e_cmp.rv, e_cmp.rpc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic csr_set(input logic [11:0] a, input logic [31:0] d);
    @(posedge clk); #2;
    bw_en = 1'b1; bw_addr = a; bw_data = d;
    @(posedge clk); #2;
    bw_en = 1'b0;
  endtask

  task automatic clear_reqs();
    trap_req = 1'b0; mret_req = 1'b0; irq_req = 1'b0;
  endtask

  // Watch n cycles: busy cycles, write cycles, first redirect cycle and its PC
  task automatic observe(input int n, output int busy_n, output int wr_n,
                         output int redir_at, output logic [31:0] redir_pc);
    busy_n = 0; wr_n = 0; redir_at = -1; redir_pc = 32'h0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (csr_we) wr_n++;
      if (redirect_valid && redir_at < 0) begin
        redir_at = i;
        redir_pc = redirect_pc;
      end
    end
  endtask

  int          b_n, w_n, r_at;
  logic [31:0] r_pc;

  initial begin
    rst = 1'b0;
    clear_reqs();
    trap_cause = 32'h0; trap_val = 32'h0; cur_pc = 32'h0; irq_code = 5'h0;
    #1 rst = 1'b1;
    #2;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_we", 32'(csr_we), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("idle_addr", 32'(csr_addr), 32'h300);
    chk("idle_redirect_valid", 32'(redirect_valid), 32'h0);
    chk("idle_redirect_pc", redirect_pc, 32'h0);

    // Exception, direct target although mtvec mode is vectored
    csr_set(12'h305, 32'h0000_0101);
    csr_set(12'h300, 32'h0000_0008);
    @(posedge clk); #2;
    trap_req = 1'b1; trap_cause = 32'd2; trap_val = 32'hDEAD_BEEF; cur_pc = 32'h0000_0104;
    @(posedge clk); #2;
    clear_reqs();
    observe(8, b_n, w_n, r_at, r_pc);
    chk("exc_busy_cycles", 32'(b_n), 32'd5);
    chk("exc_writes", 32'(w_n), 32'd4);
    chk("exc_redirect_cycle", 32'(r_at), 32'd5);
    chk("exc_redirect_pc", r_pc, 32'h0000_0100);
    chk("exc_mepc", csr_mem[12'h341], 32'h0000_0104);
    chk("exc_mcause", csr_mem[12'h342], 32'h0000_0002);
    chk("exc_mtval", csr_mem[12'h343], 32'hDEAD_BEEF);
    chk("exc_mstatus", csr_mem[12'h300], 32'h0000_1880);

    // Vectored interrupt
    csr_set(12'h305, 32'h0000_0201);
    csr_set(12'h300, 32'h0000_0008);
    @(posedge clk); #2;
    irq_req = 1'b1; irq_code = 5'd7; cur_pc = 32'h0000_0200;
    @(posedge clk); #2;
    clear_reqs();
    observe(8, b_n, w_n, r_at, r_pc);
    chk("irq_redirect_cycle", 32'(r_at), 32'd5);
    chk("irq_redirect_pc", r_pc, 32'h0000_021C);
    chk("irq_mcause", csr_mem[12'h342], 32'h8000_0007);
    chk("irq_mtval", csr_mem[12'h343], 32'h0000_0000);
    chk("irq_mepc", csr_mem[12'h341], 32'h0000_0200);

    // Masked interrupt held for 10 cycles
    csr_set(12'h300, 32'h0000_0000);
    @(posedge clk); #2;
    irq_req = 1'b1;
    observe(10, b_n, w_n, r_at, r_pc);
    @(posedge clk); #2;
    clear_reqs();
    chk("masked_busy_cycles", 32'(b_n), 32'd0);
    chk("masked_writes", 32'(w_n), 32'd0);

    // mret
    csr_set(12'h341, 32'h0000_0106);
    csr_set(12'h300, 32'h0000_0080);
    @(posedge clk); #2;
    mret_req = 1'b1;
    @(posedge clk); #2;
    clear_reqs();
    observe(6, b_n, w_n, r_at, r_pc);
    chk("mret_busy_cycles", 32'(b_n), 32'd2);
    chk("mret_writes", 32'(w_n), 32'd1);
    chk("mret_redirect_cycle", 32'(r_at), 32'd2);
    chk("mret_redirect_pc", r_pc, 32'h0000_0104);
    chk("mret_mstatus", csr_mem[12'h300], 32'h0000_1888);

    // Simultaneous requests, plus an mret pulse while busy
    csr_set(12'h300, 32'h0000_0008);
    csr_set(12'h305, 32'h0000_0101);
    @(posedge clk); #2;
    trap_req = 1'b1; mret_req = 1'b1; irq_req = 1'b1;
    trap_cause = 32'h0000_000B; trap_val = 32'h55; cur_pc = 32'h0000_0444; irq_code = 5'd3;
    @(posedge clk); #2;
    clear_reqs();
    fork
      observe(12, b_n, w_n, r_at, r_pc);
      begin
        @(posedge clk); #2 mret_req = 1'b1;
        @(posedge clk); #2 mret_req = 1'b0;
      end
    join
    chk("prio_busy_cycles", 32'(b_n), 32'd5);
    chk("prio_writes", 32'(w_n), 32'd4);
    chk("prio_redirect_pc", r_pc, 32'h0000_0100);
    chk("prio_mcause", csr_mem[12'h342], 32'h0000_000B);

    // Reset while in T_CAUSE
    csr_set(12'h342, 32'h1111_1111);
    @(posedge clk); #2;
    trap_req = 1'b1; trap_cause = 32'd5; trap_val = 32'h7; cur_pc = 32'h0000_0303;
    @(posedge clk); #2;
    clear_reqs();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_we", 32'(csr_we), 32'h0);
    chk("rst_mid_redirect_valid", 32'(redirect_valid), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk("rst_mid_mepc", csr_mem[12'h341], 32'h0000_0300);
    chk("rst_mid_mcause", csr_mem[12'h342], 32'h1111_1111);

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      clear_reqs();
      bw_en = 1'b0;
      trap_cause = {1'b0, 31'($urandom)};
      trap_val   = $urandom;
      cur_pc     = $urandom;
      irq_code   = 5'($urandom);
      if (exp_q.size() == 0 && $urandom_range(0, 9) < 2) begin
        bw_en   = 1'b1;
        bw_addr = ($urandom_range(0, 1) == 0) ? 12'h300 : 12'h305;
        bw_data = $urandom;
      end else begin
        trap_req = ($urandom_range(0, 3) == 0);
        mret_req = ($urandom_range(0, 3) == 0);
        irq_req  = ($urandom_range(0, 1) == 0);
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
    @(posedge clk); #2;
    clear_reqs();
    bw_en = 1'b0;
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
